log_event_queue: RTL and testbench

//   Synthesizable front end for the simulation logger. DUT-side sources post
//   {level, tag, msg} events; the block filters them by a runtime level

---
 rtl/log_event_queue.sv | 165 ++++++++++++++++
 tb/tb_log_event_queue.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_event_queue.sv
// rtl/log_event_queue.sv - level-filtered, sequence-numbered event FIFO feeding the simulation logger
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   cfg_min_level      minimum level kept (0=VERBOSE .. 5=FATAL), sampled every cycle
//   in_valid/in_ready  event post strobe; in_ready is constant 1 (posting never stalls)
//   in_level/tag/msg   posted event fields
//   out_valid/ready    head entry handshake toward the sink
//   out_level/tag/msg  head entry fields
//   out_seq            sequence number of the head entry
//   drop_count         saturating count of accepted-but-dropped events
//   overflow           sticky: at least one event dropped
//   fatal_seen         sticky: an accepted FATAL (stored or dropped)

module log_event_queue #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 8,
  parameter int MSG_W = 32,
  parameter int SEQ_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       cfg_min_level,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_level,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [MSG_W-1:0] in_msg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_level,
  output logic [TAG_W-1:0] out_tag,
  output logic [MSG_W-1:0] out_msg,
  output logic [SEQ_W-1:0] out_seq,
  output logic [SEQ_W-1:0] drop_count,
  output logic             overflow,
  output logic             fatal_seen
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] LVL_FATAL = 3'd5;

  typedef struct packed {
    logic [2:0]       level;
    logic [TAG_W-1:0] tag;
    logic [MSG_W-1:0] msg;
    logic [SEQ_W-1:0] seq;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head_q, head_d;
  entry_t           new_entry;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [SEQ_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;
  logic             fatal_q, fatal_d;

  logic accept;
  logic is_fatal;
  logic has_room;
  logic push;
  logic pop;

  // Every accepted event is stamped with the current seq, stored or not.
  assign new_entry = {in_level, in_tag, in_msg, seq_q};

  always_comb begin
    accept   = in_valid && (in_level >= cfg_min_level);
    is_fatal = (in_level == LVL_FATAL);
    // The last slot is held back for FATAL. Room is judged on the count at the
    // start of the cycle, so a simultaneous pop never makes room for this push.
    has_room = is_fatal ? (cnt_q < CW'(DEPTH)) : (cnt_q < CW'(DEPTH - 1));
    push     = accept && has_room;
    pop      = (cnt_q != '0) && out_ready;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    seq_d    = seq_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    fatal_d  = fatal_q;
    head_d   = head_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (accept) begin
      seq_d = seq_q + SEQ_W'(1);
      if (is_fatal) begin
        fatal_d = 1'b1;
      end
      if (!has_room) begin
        ovf_d = 1'b1;
        if (drop_q != '1) begin
          drop_d = drop_q + SEQ_W'(1);
        end
      end
    end

    // The head is kept in a register so out_* hold their last value when the
    // queue drains. If the new head slot is the one being written this cycle
    // (queue was, or becomes, empty), take the incoming entry directly.
    if (cnt_d != '0) begin
      if (push && (rd_ptr_d == wr_ptr_q)) begin
        head_d = new_entry;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
      fatal_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      fatal_q  <= fatal_d;
      head_q   <= head_d;
    end
  end

  assign in_ready   = 1'b1;
  assign out_valid  = (cnt_q != '0);
  assign out_level  = head_q.level;
  assign out_tag    = head_q.tag;
  assign out_msg    = head_q.msg;
  assign out_seq    = head_q.seq;
  assign drop_count = drop_q;
  assign overflow   = ovf_q;
  assign fatal_seen = fatal_q;

endmodule

// File: tb/tb_log_event_queue.sv
// tb/tb_log_event_queue.sv - self-checking bench for log_event_queue against a queue-based reference model

module tb_log_event_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cfg_min_level;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_level;
  logic [7:0]  in_tag;
  logic [31:0] in_msg;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_level;
  logic [7:0]  out_tag;
  logic [31:0] out_msg;
  logic [15:0] out_seq;
  logic [15:0] drop_count;
  logic        overflow;
  logic        fatal_seen;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [2:0]  level;
    logic [7:0]  tag;
    logic [31:0] msg;
    logic [15:0] seq;
  } ev_t;

  ev_t         mq[$];
  logic [15:0] m_seq;
  logic [15:0] m_drop;
  logic        m_ovf;
  logic        m_fatal;

  always #5 clk = ~clk;

  log_event_queue #(.DEPTH(16), .TAG_W(8), .MSG_W(32), .SEQ_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_min_level(cfg_min_level),
    .in_valid(in_valid), .in_ready(in_ready), .in_level(in_level),
    .in_tag(in_tag), .in_msg(in_msg),
    .out_valid(out_valid), .out_ready(out_ready), .out_level(out_level),
    .out_tag(out_tag), .out_msg(out_msg), .out_seq(out_seq),
    .drop_count(drop_count), .overflow(overflow), .fatal_seen(fatal_seen)
  );

  // Reference model: capacity is 15 for ordinary events and 16 for FATAL,
  // judged on the occupancy before the edge.
  task automatic model_update();
    int  cnt;
    bit  acc;
    bit  fat;
    ev_t e;
    if (rst) begin
      mq.delete();
      m_seq = 0; m_drop = 0; m_ovf = 0; m_fatal = 0;
    end else begin
      cnt = mq.size();
      acc = in_valid && (in_level >= cfg_min_level);
      fat = (in_level == 3'd5);
      if (cnt != 0 && out_ready) void'(mq.pop_front());
      if (acc) begin
        if (fat) m_fatal = 1;
        if (cnt < (fat ? 16 : 15)) begin
          e.level = in_level; e.tag = in_tag; e.msg = in_msg; e.seq = m_seq;
          mq.push_back(e);
        end else begin
          m_ovf = 1;
          if (m_drop != 16'hffff) m_drop = m_drop + 1;
        end
        m_seq = m_seq + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; out_ready = 0;
    tick();
    rst = 0;
  endtask

  task automatic post(input logic [2:0] lvl, input logic [7:0] tag, input logic [31:0] msg);
    in_valid = 1; in_level = lvl; in_tag = tag; in_msg = msg;
    tick();
    in_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || drop_count !== 16'd0 ||
        overflow !== 1'b0 || fatal_seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got valid=%0b ready=%0b drop=%0d ovf=%0b fatal=%0b, want 0 1 0 0 0",
               out_valid, in_ready, drop_count, overflow, fatal_seen);
    end
    vectors++;
    if (out_level !== 3'd0 || out_tag !== 8'd0 || out_msg !== 32'd0 || out_seq !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got lvl=%0d tag=%h msg=%h seq=%0d, want all 0",
               out_level, out_tag, out_msg, out_seq);
    end
  endtask

  task automatic test_basic();
    do_reset();
    cfg_min_level = 3'd2;
    post(3'd2, 8'h11, 32'hA5);
    vectors++;
    if (out_valid !== 1'b1 || out_level !== 3'd2 || out_seq !== 16'd0 ||
        out_tag !== 8'h11 || out_msg !== 32'hA5) begin
      errors++;
      $display("FAIL basic_head: got v=%0b lvl=%0d seq=%0d tag=%h msg=%h, want 1 2 0 11 a5",
               out_valid, out_level, out_seq, out_tag, out_msg);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pop: got out_valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_filter();
    do_reset();
    cfg_min_level = 3'd3;
    post(3'd1, 8'h21, 32'h1);
    post(3'd3, 8'h22, 32'h2);
    vectors++;
    if (out_valid !== 1'b1 || out_level !== 3'd3 || out_seq !== 16'd0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL filter_head: got v=%0b lvl=%0d seq=%0d drop=%0d, want 1 3 0 0",
               out_valid, out_level, out_seq, drop_count);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL filter_count: got out_valid=%0b after one pop, want 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    cfg_min_level = 3'd0;
    for (int i = 0; i < 17; i++) post(3'd2, 8'(i), 32'(i * 3));
    vectors++;
    if (drop_count !== 16'd2 || overflow !== 1'b1 || fatal_seen !== 1'b0) begin
      errors++;
      $display("FAIL overflow_flags: got drop=%0d ovf=%0b fatal=%0b, want 2 1 0",
               drop_count, overflow, fatal_seen);
    end
    for (int i = 0; i < 15; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_seq !== 16'(i) || out_msg !== 32'(i * 3)) begin
        errors++;
        $display("FAIL overflow_drain[%0d]: got v=%0b seq=%0d msg=%0d, want 1 %0d %0d",
                 i, out_valid, out_seq, out_msg, i, i * 3);
      end
      out_ready = 1;
      tick();
    end
    out_ready = 0;
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_empty: got out_valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_fatal_reserve();
    int n;
    logic [2:0]  last_lvl;
    logic [15:0] last_seq;
    do_reset();
    cfg_min_level = 3'd0;
    for (int i = 0; i < 15; i++) post(3'd2, 8'h30, 32'(i));
    post(3'd5, 8'hF0, 32'hDEAD);
    vectors++;
    if (fatal_seen !== 1'b1 || drop_count !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fatal_store: got fatal=%0b drop=%0d ovf=%0b, want 1 0 0",
               fatal_seen, drop_count, overflow);
    end
    post(3'd5, 8'hF1, 32'hBEEF);
    vectors++;
    if (drop_count !== 16'd1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL fatal_drop: got drop=%0d ovf=%0b, want 1 1", drop_count, overflow);
    end
    n = 0; last_lvl = 0; last_seq = 0;
    out_ready = 1;
    while (out_valid && n < 40) begin
      last_lvl = out_level; last_seq = out_seq; n++;
      tick();
    end
    out_ready = 0;
    vectors++;
    if (n != 16 || last_lvl !== 3'd5 || last_seq !== 16'd15) begin
      errors++;
      $display("FAIL fatal_drain: got n=%0d lvl=%0d seq=%0d, want 16 5 15", n, last_lvl, last_seq);
    end
  endtask

  task automatic test_push_pop_full();
    int n;
    logic [15:0] first_seq;
    logic [15:0] last_seq;
    do_reset();
    cfg_min_level = 3'd0;
    for (int i = 0; i < 15; i++) post(3'd2, 8'h40, 32'(i));
    out_ready = 1;
    post(3'd2, 8'h41, 32'h100);
    out_ready = 0;
    vectors++;
    if (drop_count !== 16'd1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL pushpop_drop: got drop=%0d ovf=%0b, want 1 1", drop_count, overflow);
    end
    post(3'd2, 8'h42, 32'h101);
    vectors++;
    if (drop_count !== 16'd1) begin
      errors++;
      $display("FAIL pushpop_store: got drop=%0d, want 1", drop_count);
    end
    n = 0; first_seq = out_seq; last_seq = 0;
    out_ready = 1;
    while (out_valid && n < 40) begin
      last_seq = out_seq; n++;
      tick();
    end
    out_ready = 0;
    vectors++;
    if (n != 15 || first_seq !== 16'd1 || last_seq !== 16'd16) begin
      errors++;
      $display("FAIL pushpop_drain: got n=%0d first=%0d last=%0d, want 15 1 16", n, first_seq, last_seq);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cfg_min_level = 3'd0;
    for (int i = 0; i < 17; i++) post(3'd2, 8'h50, 32'(i));
    post(3'd5, 8'h51, 32'h5);
    out_ready = 1;
    for (int i = 0; i < 8; i++) tick();
    out_ready = 0;
    do_reset();
    vectors++;
    if (out_valid !== 1'b0 || drop_count !== 16'd0 || overflow !== 1'b0 || fatal_seen !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: got v=%0b drop=%0d ovf=%0b fatal=%0b, want 0 0 0 0",
               out_valid, drop_count, overflow, fatal_seen);
    end
    post(3'd4, 8'h52, 32'h77);
    vectors++;
    if (out_valid !== 1'b1 || out_seq !== 16'd0 || out_msg !== 32'h77) begin
      errors++;
      $display("FAIL midreset_seq: got v=%0b seq=%0d msg=%h, want 1 0 77", out_valid, out_seq, out_msg);
    end
  endtask

  task automatic test_random();
    int ready_pct;
    do_reset();
    ready_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        cfg_min_level = 3'($urandom_range(0, 6));
        ready_pct = $urandom_range(5, 95);
      end
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 99) < 80);
      in_level  = 3'($urandom_range(0, 7));
      in_tag    = 8'($urandom);
      in_msg    = $urandom;
      out_ready = ($urandom_range(0, 99) < ready_pct);
      tick();
      vectors++;
      if (out_valid !== (mq.size() != 0) || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rand_valid c=%0d: got v=%0b rdy=%0b, want v=%0b rdy=1",
                 c, out_valid, in_ready, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        vectors++;
        if (out_level !== mq[0].level || out_tag !== mq[0].tag ||
            out_msg !== mq[0].msg || out_seq !== mq[0].seq) begin
          errors++;
          $display("FAIL rand_head c=%0d: got %0d/%h/%h/%0d, want %0d/%h/%h/%0d", c,
                   out_level, out_tag, out_msg, out_seq,
                   mq[0].level, mq[0].tag, mq[0].msg, mq[0].seq);
        end
      end
      vectors++;
      if (drop_count !== m_drop || overflow !== m_ovf || fatal_seen !== m_fatal) begin
        errors++;
        $display("FAIL rand_flags c=%0d: got drop=%0d ovf=%0b fatal=%0b, want %0d %0b %0b",
                 c, drop_count, overflow, fatal_seen, m_drop, m_ovf, m_fatal);
      end
    end
    rst = 0; in_valid = 0; out_ready = 0;
  endtask

  initial begin
    rst = 1; cfg_min_level = 0; in_valid = 0; in_level = 0;
    in_tag = 0; in_msg = 0; out_ready = 0;
    test_reset();
    test_basic();
    test_filter();
    test_overflow();
    test_fatal_reserve();
    test_push_pop_full();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
